// File: rtl/id_stage_pipe.sv
// id_stage_pipe: instruction decode stage with an internal register file,
// sign-extended immediate generation, load-use hazard bubbles, flush, and
// a registered ID/EX stage with valid/ready handshakes on both sides.
// Optional feature macro: ID_WB_BYPASS_EN (write-first register file reads).
module id_stage_pipe #(
   parameter int DATA_WIDTH = 32,
   parameter int NUM_REGS   = 32,
   parameter int RA_W       = $clog2(NUM_REGS),
   parameter int CNT_W      = 16
) (
   input  logic                  clk,
   input  logic                  arst_n,
   input  logic                  if_valid_i,
   output logic                  if_ready_o,
   input  logic [31:0]           if_inst_i,
   input  logic [DATA_WIDTH-1:0] if_pc_i,
   input  logic                  flush_i,
   input  logic                  wb_en_i,
   input  logic [RA_W-1:0]       wb_rd_i,
   input  logic [DATA_WIDTH-1:0] wb_data_i,
   output logic                  ex_valid_o,
   input  logic                  ex_ready_i,
   output logic [DATA_WIDTH-1:0] ex_pc_o,
   output logic [DATA_WIDTH-1:0] ex_opr_a_o,
   output logic [DATA_WIDTH-1:0] ex_opr_b_o,
   output logic [DATA_WIDTH-1:0] ex_imm_o,
   output logic [RA_W-1:0]       ex_rd_o,
   output logic [RA_W-1:0]       ex_rs1_o,
   output logic [RA_W-1:0]       ex_rs2_o,
   output logic [6:0]            ex_opcode_o,
   output logic [2:0]            ex_funct3_o,
   output logic [6:0]            ex_funct7_o,
   output logic                  ex_is_load_o,
   output logic [CNT_W-1:0]      stall_cnt_o
);

   typedef enum logic [6:0] {
      OP_LOAD   = 7'b0000011,
      OP_OPIMM  = 7'b0010011,
      OP_JALR   = 7'b1100111,
      OP_STORE  = 7'b0100011,
      OP_BRANCH = 7'b1100011,
      OP_LUI    = 7'b0110111,
      OP_AUIPC  = 7'b0010111,
      OP_JAL    = 7'b1101111,
      OP_OP     = 7'b0110011
   } opcode_e;

   logic [DATA_WIDTH-1:0] rf [NUM_REGS];

   logic [6:0]            dec_opcode;
   logic [2:0]            dec_funct3;
   logic [6:0]            dec_funct7;
   logic [RA_W-1:0]       dec_rd;
   logic [RA_W-1:0]       dec_rs1;
   logic [RA_W-1:0]       dec_rs2;
   logic [31:0]           imm32;
   logic [DATA_WIDTH-1:0] dec_imm;
   logic [DATA_WIDTH-1:0] rd_data_a;
   logic [DATA_WIDTH-1:0] rd_data_b;
   logic                  uses_rs1;
   logic                  uses_rs2;
   logic                  hazard;
   logic                  advance;
   logic                  wb_active;

   assign dec_opcode = if_inst_i[6:0];
   assign dec_funct3 = if_inst_i[14:12];
   assign dec_funct7 = if_inst_i[31:25];
   assign dec_rd     = if_inst_i[7 +: RA_W];
   assign dec_rs1    = if_inst_i[15 +: RA_W];
   assign dec_rs2    = if_inst_i[20 +: RA_W];
   assign wb_active  = wb_en_i && (wb_rd_i != '0);

   // Register file read: entry 0 is hardwired to zero.
   function automatic logic [DATA_WIDTH-1:0] rf_read(input logic [RA_W-1:0] idx);
      logic [DATA_WIDTH-1:0] val;
      if (idx == '0) begin
         val = '0;
      end else begin
         val = rf[idx];
`ifdef ID_WB_BYPASS_EN
         if (wb_active && (wb_rd_i == idx)) val = wb_data_i;
`endif
      end
      return val;
   endfunction

   // Register file write port; reset clears every entry.
   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         for (int unsigned i = 0; i < NUM_REGS; i++) rf[i] <= '0;
      end else if (wb_active) begin
         rf[wb_rd_i] <= wb_data_i;
      end
   end

   // Operand reads for the instruction presented by fetch.
   always_comb begin
      rd_data_a = rf_read(dec_rs1);
      rd_data_b = rf_read(dec_rs2);
   end

   // Immediate selection by opcode, then sign extension to DATA_WIDTH.
   always_comb begin
      imm32 = '0;
      case (dec_opcode)
         OP_OPIMM, OP_LOAD, OP_JALR:
            imm32 = {{20{if_inst_i[31]}}, if_inst_i[31:20]};
         OP_STORE:
            imm32 = {{20{if_inst_i[31]}}, if_inst_i[31:25], if_inst_i[11:7]};
         OP_BRANCH:
            imm32 = {{19{if_inst_i[31]}}, if_inst_i[31], if_inst_i[7],
                     if_inst_i[30:25], if_inst_i[11:8], 1'b0};
         OP_LUI, OP_AUIPC:
            imm32 = {if_inst_i[31:12], 12'b0};
         OP_JAL:
            imm32 = {{11{if_inst_i[31]}}, if_inst_i[31], if_inst_i[19:12],
                     if_inst_i[20], if_inst_i[30:21], 1'b0};
         default:
            imm32 = '0;
      endcase
      dec_imm = DATA_WIDTH'($signed(imm32));
   end

   // Operand usage, load-use hazard detection and handshake.
   always_comb begin
      uses_rs1 = !((dec_opcode == OP_LUI) || (dec_opcode == OP_AUIPC) ||
                   (dec_opcode == OP_JAL));
      uses_rs2 = (dec_opcode == OP_OP) || (dec_opcode == OP_STORE) ||
                 (dec_opcode == OP_BRANCH);
      hazard   = if_valid_i && ex_valid_o && ex_is_load_o && (ex_rd_o != '0) &&
                 ((uses_rs1 && (dec_rs1 == ex_rd_o)) ||
                  (uses_rs2 && (dec_rs2 == ex_rd_o)));
      advance    = !ex_valid_o || ex_ready_i;
      if_ready_o = flush_i || (advance && !hazard);
   end

   // ID/EX register: flush, bubble, load, drain or hold (in priority order).
   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         ex_valid_o   <= 1'b0;
         ex_pc_o      <= '0;
         ex_opr_a_o   <= '0;
         ex_opr_b_o   <= '0;
         ex_imm_o     <= '0;
         ex_rd_o      <= '0;
         ex_rs1_o     <= '0;
         ex_rs2_o     <= '0;
         ex_opcode_o  <= '0;
         ex_funct3_o  <= '0;
         ex_funct7_o  <= '0;
         ex_is_load_o <= 1'b0;
      end else if (flush_i) begin
         ex_valid_o <= 1'b0;
      end else if (advance && hazard) begin
         ex_valid_o <= 1'b0;
      end else if (advance && if_valid_i) begin
         ex_valid_o   <= 1'b1;
         ex_pc_o      <= if_pc_i;
         ex_opr_a_o   <= rd_data_a;
         ex_opr_b_o   <= rd_data_b;
         ex_imm_o     <= dec_imm;
         ex_rd_o      <= dec_rd;
         ex_rs1_o     <= dec_rs1;
         ex_rs2_o     <= dec_rs2;
         ex_opcode_o  <= dec_opcode;
         ex_funct3_o  <= dec_funct3;
         ex_funct7_o  <= dec_funct7;
         ex_is_load_o <= (dec_opcode == OP_LOAD);
      end else if (advance) begin
         ex_valid_o <= 1'b0;
      end else begin
         // Held: keep operands coherent with writebacks landing meanwhile.
         if (wb_active && (wb_rd_i == ex_rs1_o)) ex_opr_a_o <= wb_data_i;
         if (wb_active && (wb_rd_i == ex_rs2_o)) ex_opr_b_o <= wb_data_i;
      end
   end

   // Saturating count of hazard bubble cycles; a flush takes precedence.
   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         stall_cnt_o <= '0;
      end else if (!flush_i && advance && hazard && (stall_cnt_o != '1)) begin
         stall_cnt_o <= stall_cnt_o + 1'b1;
      end
   end

endmodule

// File: tb/tb_id_stage_pipe.sv
// tb_id_stage_pipe: directed-vector bench for id_stage_pipe (default parameters).
module tb_id_stage_pipe;

   logic        clk = 1'b0;
   logic        arst_n;
   logic        if_valid_i;
   logic        if_ready_o;
   logic [31:0] if_inst_i;
   logic [31:0] if_pc_i;
   logic        flush_i;
   logic        wb_en_i;
   logic [4:0]  wb_rd_i;
   logic [31:0] wb_data_i;
   logic        ex_valid_o;
   logic        ex_ready_i;
   logic [31:0] ex_pc_o;
   logic [31:0] ex_opr_a_o;
   logic [31:0] ex_opr_b_o;
   logic [31:0] ex_imm_o;
   logic [4:0]  ex_rd_o;
   logic [4:0]  ex_rs1_o;
   logic [4:0]  ex_rs2_o;
   logic [6:0]  ex_opcode_o;
   logic [2:0]  ex_funct3_o;
   logic [6:0]  ex_funct7_o;
   logic        ex_is_load_o;
   logic [15:0] stall_cnt_o;

   int total = 0;
   int bad   = 0;

   id_stage_pipe #(.DATA_WIDTH(32), .NUM_REGS(32), .CNT_W(16)) dut (
      .clk(clk), .arst_n(arst_n),
      .if_valid_i(if_valid_i), .if_ready_o(if_ready_o),
      .if_inst_i(if_inst_i), .if_pc_i(if_pc_i), .flush_i(flush_i),
      .wb_en_i(wb_en_i), .wb_rd_i(wb_rd_i), .wb_data_i(wb_data_i),
      .ex_valid_o(ex_valid_o), .ex_ready_i(ex_ready_i),
      .ex_pc_o(ex_pc_o), .ex_opr_a_o(ex_opr_a_o), .ex_opr_b_o(ex_opr_b_o),
      .ex_imm_o(ex_imm_o), .ex_rd_o(ex_rd_o), .ex_rs1_o(ex_rs1_o),
      .ex_rs2_o(ex_rs2_o), .ex_opcode_o(ex_opcode_o), .ex_funct3_o(ex_funct3_o),
      .ex_funct7_o(ex_funct7_o), .ex_is_load_o(ex_is_load_o),
      .stall_cnt_o(stall_cnt_o)
   );

   // 10 ns clock.
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wb_write(input logic [4:0] rd, input logic [31:0] data);
      wb_en_i = 1'b1; wb_rd_i = rd; wb_data_i = data;
      step();
      wb_en_i = 1'b0;
   endtask

   localparam logic [31:0] I_ADDI_6_5  = 32'hFFF28313; // addi x6,x5,-1
   localparam logic [31:0] I_LW_7_1    = 32'h0000A383; // lw x7,0(x1)
   localparam logic [31:0] I_ADD_8_7_2 = 32'h00238433; // add x8,x7,x2
   localparam logic [31:0] I_ADD_8_2_3 = 32'h00310433; // add x8,x2,x3
   localparam logic [31:0] I_ADD_10_9  = 32'h00048533; // add x10,x9,x0
   localparam logic [31:0] I_LUI_11    = 32'h123455B7; // lui x11,0x12345
   localparam logic [31:0] I_SW_2_M8   = 32'hFE20AC23; // sw x2,-8(x1)
   localparam logic [31:0] I_ADDI_12_1 = 32'h00008613; // addi x12,x1,0

   initial begin
      arst_n = 1'b0; if_valid_i = 1'b0; if_inst_i = '0; if_pc_i = '0;
      flush_i = 1'b0; wb_en_i = 1'b0; wb_rd_i = '0; wb_data_i = '0; ex_ready_i = 1'b1;
      #12;
      check_eq("rst_valid", ex_valid_o, 0);
      check_eq("rst_stall", stall_cnt_o, 0);
      arst_n = 1'b1;
      step();

      wb_write(5'd1, 32'h0000_0100);
      wb_write(5'd2, 32'h0000_0022);
      wb_write(5'd3, 32'h0000_0033);
      wb_write(5'd5, 32'hDEAD_BEEF);
      wb_write(5'd9, 32'h0000_1111);
      wb_write(5'd0, 32'hFFFF_FFFF); // x0 must stay zero

      // addi x6,x5,-1
      if_valid_i = 1'b1; if_inst_i = I_ADDI_6_5; if_pc_i = 32'h40;
      #1 check_eq("addi_ready", if_ready_o, 1);
      step();
      check_eq("addi_valid", ex_valid_o, 1);
      check_eq("addi_opa", ex_opr_a_o, 32'hDEADBEEF);
      check_eq("addi_imm", ex_imm_o, 32'hFFFFFFFF);
      check_eq("addi_rd", ex_rd_o, 6);
      check_eq("addi_pc", ex_pc_o, 32'h40);
      check_eq("addi_op", ex_opcode_o, 7'h13);

      // lui and sw immediates
      if_inst_i = I_LUI_11; if_pc_i = 32'h44;
      step();
      check_eq("lui_imm", ex_imm_o, 32'h12345000);
      if_inst_i = I_SW_2_M8; if_pc_i = 32'h48;
      step();
      check_eq("sw_imm", ex_imm_o, 32'hFFFFFFF8);
      check_eq("sw_opb", ex_opr_b_o, 32'h22);
      check_eq("sw_f3", ex_funct3_o, 2);

      // load-use: lw x7 then add x8,x7,x2 -> one bubble
      if_inst_i = I_LW_7_1; if_pc_i = 32'h4C;
      step();
      check_eq("lw_load", ex_is_load_o, 1);
      check_eq("lw_opa", ex_opr_a_o, 32'h100);
      if_inst_i = I_ADD_8_7_2; if_pc_i = 32'h50;
      #1 check_eq("haz_ready", if_ready_o, 0);
      step();
      check_eq("bub_valid", ex_valid_o, 0);
      check_eq("bub_cnt", stall_cnt_o, 1);
      check_eq("bub_ready", if_ready_o, 1);
      step();
      check_eq("add_valid", ex_valid_o, 1);
      check_eq("add_rd", ex_rd_o, 8);
      check_eq("add_pc", ex_pc_o, 32'h50);
      check_eq("add_opa", ex_opr_a_o, 0);
      check_eq("add_opb", ex_opr_b_o, 32'h22);

      // lw then independent add -> no bubble
      if_inst_i = I_LW_7_1; if_pc_i = 32'h54;
      step();
      if_inst_i = I_ADD_8_2_3; if_pc_i = 32'h58;
      #1 check_eq("nohaz_ready", if_ready_o, 1);
      step();
      check_eq("nohaz_valid", ex_valid_o, 1);
      check_eq("nohaz_pc", ex_pc_o, 32'h58);
      check_eq("nohaz_cnt", stall_cnt_o, 1);
      check_eq("nohaz_opa", ex_opr_a_o, 32'h22);

      // back-pressure: hold for 3 cycles
      ex_ready_i = 1'b0; if_inst_i = I_ADDI_6_5; if_pc_i = 32'h5C;
      #1 check_eq("hold_ready", if_ready_o, 0);
      for (int i = 0; i < 3; i++) begin
         step();
         check_eq("hold_valid", ex_valid_o, 1);
         check_eq("hold_pc", ex_pc_o, 32'h58);
         check_eq("hold_rd", ex_rd_o, 8);
      end
      wb_write(5'd2, 32'h0000_0777);
      check_eq("refresh_opa", ex_opr_a_o, 32'h777);
      check_eq("refresh_opb", ex_opr_b_o, 32'h33);

      // flush while held with an incoming instruction
      flush_i = 1'b1;
      #1 check_eq("flush_ready", if_ready_o, 1);
      step();
      check_eq("flush_valid", ex_valid_o, 0);
      check_eq("flush_cnt", stall_cnt_o, 1);
      flush_i = 1'b0; ex_ready_i = 1'b1;

      // same-cycle writeback of the source register
      if_inst_i = I_ADD_10_9; if_pc_i = 32'h60;
      wb_en_i = 1'b1; wb_rd_i = 5'd9; wb_data_i = 32'h1234;
      step();
      wb_en_i = 1'b0;
`ifdef ID_WB_BYPASS_EN
      check_eq("byp_opa", ex_opr_a_o, 32'h1234);
`else
      check_eq("byp_opa", ex_opr_a_o, 32'h1111);
`endif
      step();
      check_eq("after_wb_opa", ex_opr_a_o, 32'h1234);
      check_eq("x0_opb", ex_opr_b_o, 0);

      // asynchronous reset mid-stream
      #3 arst_n = 1'b0;
      #1;
      check_eq("arst_valid", ex_valid_o, 0);
      check_eq("arst_opa", ex_opr_a_o, 0);
      check_eq("arst_rd", ex_rd_o, 0);
      check_eq("arst_cnt", stall_cnt_o, 0);
      step();
      arst_n = 1'b1;
      if_inst_i = I_ADDI_12_1; if_pc_i = 32'h64;
      step();
      check_eq("post_rst_valid", ex_valid_o, 1);
      check_eq("post_rst_x1", ex_opr_a_o, 0);
      if_valid_i = 1'b0;
      step();
      check_eq("drain_valid", ex_valid_o, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1, "timeout");
   end

endmodule
